// File: rtl/game_pkg.sv
// Shared game definitions: grid-dimension lookup, cell index type and the
// reveal sequencer state encoding.
package game_pkg;

  typedef logic [4:0] idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SHOW,
    ST_GAP,
    ST_ADV,
    ST_DONE
  } reveal_state_t;

  function automatic idx_t level_dim(input logic [1:0] level);
    case (level)
      2'd1:    return 5'd8;
      2'd2:    return 5'd16;
      2'd3:    return 5'd24;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Registered rising-edge detector with asynchronous active-low reset;
// the pulse appears one cycle after the input rises.
module edge_detector (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sig_q <= sig;
      rise  <= sig & ~sig_q;
    end
  end

endmodule

// File: rtl/mine_reveal_seq.sv
// After a lost game, scans the mine map in raster order and shows each mine
// (index + explode) for a fixed number of video frames, one mine at a time.
module mine_reveal_seq
  import game_pkg::*;
#(
  parameter int FRAMES_PER_MINE = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] level,
  input  logic       start,
  input  logic       abort,
  input  logic       vblnk,
  output logic       map_rd_en,
  output logic [4:0] map_x,
  output logic [4:0] map_y,
  input  logic       map_mine,
  output logic [4:0] mine_ind_x,
  output logic [4:0] mine_ind_y,
  output logic       explode,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] FPM = FRAMES_PER_MINE[7:0];

  reveal_state_t state, state_next;
  idx_t          cur_x, cur_y, cur_x_next, cur_y_next;
  idx_t          ind_x_next, ind_y_next;
  idx_t          dim;
  logic [1:0]    lvl_q, lvl_next;
  logic [7:0]    frame_cnt, cnt_next;
  logic          vblnk_rise;
  logic          start_ok;

  edge_detector u_vblnk_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (vblnk),
    .rise  (vblnk_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cur_x_next = cur_x;
    cur_y_next = cur_y;
    lvl_next   = lvl_q;
    cnt_next   = frame_cnt;
    ind_x_next = mine_ind_x;
    ind_y_next = mine_ind_y;
    dim        = level_dim(lvl_q);
    start_ok   = start && (level != 2'd0);

    if (abort) begin
      state_next = ST_IDLE;
      cur_x_next = '0;
      cur_y_next = '0;
      ind_x_next = '0;
      ind_y_next = '0;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state_next = ST_REQ;
            cur_x_next = 5'd1;
            cur_y_next = 5'd1;
            lvl_next   = level;
          end
        end
        ST_REQ: state_next = ST_WAIT;
        ST_WAIT: begin
          if (map_mine) begin
            state_next = ST_SHOW;
            ind_x_next = cur_x;
            ind_y_next = cur_y;
            cnt_next   = '0;
          end else begin
            state_next = ST_ADV;
          end
        end
        // Frame ticks outside SHOW never reach the counter.
        ST_SHOW: begin
          if (vblnk_rise) begin
            if (frame_cnt != 8'hFF) cnt_next = frame_cnt + 8'd1;
            if (cnt_next >= FPM) state_next = ST_GAP;
          end
        end
        ST_GAP: state_next = ST_ADV;
        ST_ADV: begin
          if (cur_x == dim && cur_y == dim) begin
            state_next = ST_DONE;
          end else if (cur_x == dim) begin
            cur_x_next = 5'd1;
            cur_y_next = cur_y + 5'd1;
            state_next = ST_REQ;
          end else begin
            cur_x_next = cur_x + 5'd1;
            state_next = ST_REQ;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x      <= '0;
      cur_y      <= '0;
      lvl_q      <= '0;
      frame_cnt  <= '0;
      mine_ind_x <= '0;
      mine_ind_y <= '0;
      map_rd_en  <= 1'b0;
      explode    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      cur_x      <= cur_x_next;
      cur_y      <= cur_y_next;
      lvl_q      <= lvl_next;
      frame_cnt  <= cnt_next;
      mine_ind_x <= ind_x_next;
      mine_ind_y <= ind_y_next;
      map_rd_en  <= (state_next == ST_REQ);
      explode    <= (state_next == ST_SHOW);
      busy       <= (state_next != ST_IDLE) && (state_next != ST_DONE);
      done       <= (state_next == ST_DONE);
    end
  end

  assign map_x = cur_x;
  assign map_y = cur_y;

endmodule

// File: tb/tb_mine_reveal_seq.sv
// Self-checking bench for mine_reveal_seq: cycle-exact vector table plus
// directed full-scan sequences against a behavioural mine map.
module tb_mine_reveal_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] level = 2'd0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       vblnk;
  logic       map_rd_en;
  logic [4:0] map_x, map_y;
  logic       map_mine;
  logic [4:0] mine_ind_x, mine_ind_y;
  logic       explode, busy, done;

  logic man_vblnk = 1'b0;
  logic gen_vblnk = 1'b0;
  logic gen_en = 1'b0;
  assign vblnk = gen_en ? gen_vblnk : man_vblnk;

  int checks = 0;
  int errors = 0;

  bit mine_map [0:31][0:31];

  int   scan_gen = 0;
  int   scan_dim = 0;
  int   seen_gen = 0;
  int   busy_cycles = 0;
  int   explode_cycles = 0;
  int   reads = 0;
  int   raster_err = 0;
  int   n_shown = 0;
  logic [4:0] exp_x = 5'd1, exp_y = 5'd1;
  logic [4:0] shown_x [0:7];
  logic [4:0] shown_y [0:7];
  logic explode_prev = 1'b0;

  wire [23:0] outs = {map_rd_en, map_x, map_y, explode, mine_ind_x, mine_ind_y, busy, done};

  mine_reveal_seq #(.FRAMES_PER_MINE(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .level      (level),
    .start      (start),
    .abort      (abort),
    .vblnk      (vblnk),
    .map_rd_en  (map_rd_en),
    .map_x      (map_x),
    .map_y      (map_y),
    .map_mine   (map_mine),
    .mine_ind_x (mine_ind_x),
    .mine_ind_y (mine_ind_y),
    .explode    (explode),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (3) @(posedge clk);
    #2 gen_vblnk = ~gen_vblnk;
  end

  // Synchronous-read mine map: data valid the cycle after the read strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) map_mine <= 1'b0;
    else        map_mine <= map_rd_en && mine_map[map_x][map_y];
  end

  // Scan monitor: raster-order address model, shown-mine log, cycle counts.
  always @(negedge clk) begin
    if (scan_gen != seen_gen) begin
      seen_gen       = scan_gen;
      exp_x          = 5'd1;
      exp_y          = 5'd1;
      reads          = 0;
      raster_err     = 0;
      n_shown        = 0;
      busy_cycles    = 0;
      explode_cycles = 0;
    end
    if (busy) busy_cycles++;
    if (explode) explode_cycles++;
    if (explode && !explode_prev && n_shown < 8) begin
      shown_x[n_shown] = mine_ind_x;
      shown_y[n_shown] = mine_ind_y;
      n_shown++;
    end
    explode_prev = explode;
    if (map_rd_en) begin
      reads++;
      if (map_x !== exp_x || map_y !== exp_y) raster_err++;
      if (exp_x == scan_dim[4:0]) begin
        exp_x = 5'd1;
        exp_y = exp_y + 5'd1;
      end else begin
        exp_x = exp_x + 5'd1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic       start;
    logic       abort;
    logic [1:0] level;
    logic       vblnk;
    logic [23:0] expect_outs;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic st, input logic ab, input logic [1:0] lv,
                              input logic vb, input logic rd, input int mx, input int my,
                              input logic ex, input int ix, input int iy,
                              input logic bz, input logic dn);
    vec_t v;
    v.start = st;
    v.abort = ab;
    v.level = lv;
    v.vblnk = vb;
    v.expect_outs = {rd, mx[4:0], my[4:0], ex, ix[4:0], iy[4:0], bz, dn};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start     = v.start;
    abort     = v.abort;
    level     = v.level;
    man_vblnk = v.vblnk;
  endtask

  task automatic clearMap();
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        mine_map[x][y] = 1'b0;
  endtask

  task automatic startScan(input logic [1:0] lv, input int dimv);
    scan_gen++;
    scan_dim = dimv;
    level = lv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic abortCycle();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic waitExplode(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (explode) begin ok = 1'b1; break; end
    end
  endtask

  task automatic waitDone(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    bit ok;

    vecs[0]  = mk(1, 0, 1, 0,  1, 1, 1,  0, 0, 0,  1, 0);
    vecs[1]  = mk(0, 0, 1, 0,  0, 1, 1,  0, 0, 0,  1, 0);
    vecs[2]  = mk(0, 0, 1, 0,  0, 1, 1,  0, 0, 0,  1, 0);
    vecs[3]  = mk(0, 0, 3, 0,  1, 2, 1,  0, 0, 0,  1, 0);
    vecs[4]  = mk(0, 0, 3, 0,  0, 2, 1,  0, 0, 0,  1, 0);
    vecs[5]  = mk(1, 0, 3, 0,  0, 2, 1,  1, 2, 1,  1, 0);
    vecs[6]  = mk(0, 0, 1, 1,  0, 2, 1,  1, 2, 1,  1, 0);
    vecs[7]  = mk(0, 0, 1, 1,  0, 2, 1,  1, 2, 1,  1, 0);
    vecs[8]  = mk(0, 0, 1, 0,  0, 2, 1,  1, 2, 1,  1, 0);
    vecs[9]  = mk(0, 0, 1, 1,  0, 2, 1,  1, 2, 1,  1, 0);
    vecs[10] = mk(0, 0, 1, 0,  0, 2, 1,  0, 2, 1,  1, 0);
    vecs[11] = mk(0, 0, 1, 0,  0, 2, 1,  0, 2, 1,  1, 0);
    vecs[12] = mk(0, 0, 1, 0,  1, 3, 1,  0, 2, 1,  1, 0);
    vecs[13] = mk(1, 1, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0);
    vecs[14] = mk(1, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0);

    clearMap();
    mine_map[2][1] = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outputs", 32'(outs), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Cycle-exact walk through an empty cell, a mine at (2,1), GAP and abort.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk); #1;
      checkOutput($sformatf("vector %0d", i), 32'(outs), 32'(vecs[i].expect_outs));
    end
    start = 1'b0;
    level = 2'd0;

    // Level 1, single mine at (3,2), explode timed by hand-driven vblnk.
    clearMap();
    mine_map[3][2] = 1'b1;
    startScan(2'd1, 8);
    waitExplode(100, ok);
    checkOutput("A explode seen", 32'(ok), 32'd1);
    checkOutput("A mine index", {22'd0, mine_ind_x, mine_ind_y}, {22'd0, 5'd3, 5'd2});
    man_vblnk = 1'b1;
    @(posedge clk); #1;
    checkOutput("A explode after edge1", 32'(explode), 32'd1);
    @(posedge clk); #1;
    man_vblnk = 1'b0;
    @(posedge clk); #1;
    man_vblnk = 1'b1;
    @(posedge clk); #1;
    checkOutput("A explode before edge2 seen", 32'(explode), 32'd1);
    @(posedge clk); #1;
    checkOutput("A explode after edge2", 32'(explode), 32'd0);
    man_vblnk = 1'b0;
    waitDone(400, ok);
    checkOutput("A done reached", 32'(ok), 32'd1);
    checkOutput("A busy cycles", 32'(busy_cycles), 32'd198);
    checkOutput("A mines shown", 32'(n_shown), 32'd1);
    abortCycle();

    // Level 2, mines (16,1) and (1,2): row wrap and back-to-back shows.
    clearMap();
    mine_map[16][1] = 1'b1;
    mine_map[1][2]  = 1'b1;
    gen_en = 1'b1;
    startScan(2'd2, 16);
    level = 2'd1;
    waitDone(1500, ok);
    checkOutput("B done reached", 32'(ok), 32'd1);
    checkOutput("B mines shown", 32'(n_shown), 32'd2);
    checkOutput("B first mine", {22'd0, shown_x[0], shown_y[0]}, {22'd0, 5'd16, 5'd1});
    checkOutput("B second mine", {22'd0, shown_x[1], shown_y[1]}, {22'd0, 5'd1, 5'd2});
    checkOutput("B raster order", 32'(raster_err), 32'd0);
    checkOutput("B read count", 32'(reads), 32'd256);
    abortCycle();

    // Level 3, empty map.
    clearMap();
    gen_en = 1'b1;
    startScan(2'd3, 24);
    waitDone(2500, ok);
    checkOutput("C done reached", 32'(ok), 32'd1);
    checkOutput("C busy cycles", 32'(busy_cycles), 32'd1728);
    checkOutput("C explode cycles", 32'(explode_cycles), 32'd0);
    checkOutput("C read count", 32'(reads), 32'd576);
    startScan(2'd1, 8);
    checkOutput("C restart from done", {30'd0, busy, done}, 32'b10);
    abortCycle();

    // Level 3, mine in the last cell.
    clearMap();
    mine_map[24][24] = 1'b1;
    startScan(2'd3, 24);
    waitDone(2500, ok);
    checkOutput("D done reached", 32'(ok), 32'd1);
    checkOutput("D mines shown", 32'(n_shown), 32'd1);
    checkOutput("D last mine", {22'd0, shown_x[0], shown_y[0]}, {22'd0, 5'd24, 5'd24});
    checkOutput("D raster order", 32'(raster_err), 32'd0);
    checkOutput("D read count", 32'(reads), 32'd576);
    abortCycle();

    // Abort in the middle of SHOW, with a simultaneous start.
    clearMap();
    mine_map[1][1] = 1'b1;
    gen_en = 1'b0;
    man_vblnk = 1'b0;
    startScan(2'd1, 8);
    waitExplode(20, ok);
    checkOutput("E explode seen", 32'(ok), 32'd1);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    checkOutput("E abort outputs", 32'(outs), 32'd0);
    @(posedge clk); #1;
    checkOutput("E stays idle", {30'd0, busy, done}, 32'd0);

    // Asynchronous reset mid-scan, then a start with level 0.
    clearMap();
    startScan(2'd3, 24);
    repeat (40) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("F async reset outputs", 32'(outs), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    level = 2'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("F level0 start ignored", 32'(outs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
